// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_ODD_PARITY_EN for odd parity; even parity by default.
module uart_transmitter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  start,
  input  logic                  parity_en,
  input  logic                  two_stop_bits,
  input  logic [1:0]            word_length,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             par_en_q, par_en_d;
  logic             two_stop_q, two_stop_d;
  logic [1:0]       wl_q, wl_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  logic       bit_end;
  logic [2:0] last_idx;
  logic       par_bit;

  assign bit_end  = (cnt_q == CNT_MAX);
  assign last_idx = {1'b0, wl_q} + 3'd4;

  // Bits above the word length are cleared when latched, so parity is a plain reduction.
`ifdef UART_TX_ODD_PARITY_EN
  assign par_bit = ~^data_q;
`else
  assign par_bit = ^data_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    wl_d       = wl_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (start) begin
          data_d     = data_in[7:0] & (8'hFF >> (2'd3 - word_length));
          par_en_d   = parity_en;
          two_stop_d = two_stop_bits;
          wl_d       = word_length;
          state_d    = S_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == last_idx) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = S_STOP1;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_q + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP1;
          tx_d    = 1'b1;
        end
      end
      S_STOP1: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (two_stop_q) begin
            state_d = S_STOP2;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      S_STOP2: begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      wl_q       <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      wl_q       <= wl_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frames predicted from the UART framing rules and compared
// cycle by cycle against tx/tx_busy, using a short bit period to keep runs brief.
module tb_uart_transmitter;

  localparam int unsigned CLK_FREQ  = 160;
  localparam int unsigned BAUD_RATE = 10;
  localparam int unsigned BD        = CLK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = '0;
  logic       start = 1'b0;
  logic       parity_en = 1'b0;
  logic       two_stop_bits = 1'b0;
  logic [1:0] word_length = '0;
  logic       tx;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;

  uart_transmitter #(
    .DATA_WIDTH(8),
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .start        (start),
    .parity_en    (parity_en),
    .two_stop_bits(two_stop_bits),
    .word_length  (word_length),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  // Caller is at a falling edge with the DUT idle; returns at the falling edge after the frame.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s2,
                            input logic [1:0] wl, input bit noise, input bit hold,
                            input string name);
    logic        exp_bits[$];
    int unsigned n;
    logic        par;
    logic        bad_tx, bad_busy;
    bit          ok;
    n   = int'(wl) + 5;
    par = 1'b0;
    exp_bits.push_back(1'b0);
    for (int unsigned i = 0; i < n; i++) begin
      exp_bits.push_back(d[i]);
      par = par ^ d[i];
    end
`ifdef UART_TX_ODD_PARITY_EN
    par = ~par;
`endif
    if (p) exp_bits.push_back(par);
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);

    data_in = d; parity_en = p; two_stop_bits = s2; word_length = wl; start = 1'b1;
    @(posedge clk);
    for (int b = 0; b < exp_bits.size(); b++) begin
      ok = 1'b1; bad_tx = 1'bx; bad_busy = 1'bx;
      for (int unsigned c = 0; c < BD; c++) begin
        @(negedge clk);
        if (noise) begin
          data_in = 8'($urandom); parity_en = 1'($urandom); two_stop_bits = 1'($urandom);
          word_length = 2'($urandom);
          start = hold ? 1'b1 : ($urandom_range(0, 3) == 0);
        end else if (!hold) begin
          start = 1'b0;
        end
        if (ok && (tx !== exp_bits[b] || tx_busy !== 1'b1)) begin
          ok = 1'b0; bad_tx = tx; bad_busy = tx_busy;
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s bit%0d: tx=%b busy=%b, required tx=%b busy=1", name, b, bad_tx,
                 bad_busy, exp_bits[b]);
      end
    end
    @(negedge clk);
    if (!hold) start = 1'b0;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end: tx=%b busy=%b, required tx=1 busy=0", name, tx, tx_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: tx=%b busy=%b, required tx=1 busy=0", tx, tx_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: tx=%b busy=%b, required tx=1 busy=0", tx, tx_busy);
    end
  endtask

  task automatic test_directed();
    send_frame(8'h55, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, "8n1_55");
    send_frame(8'h43, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, "8e1_43");
    send_frame(8'h41, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, "8e1_41");
    send_frame(8'hAA, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, "8n2_aa");
    send_frame(8'h0F, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "5n1_0f");
    send_frame(8'h7F, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, "7n1_7f");
    send_frame(8'hE0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, "5e1_e0_high_bits");
    send_frame(8'hC5, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, "6e2_c5");
  endtask

  task automatic test_input_changes();
    send_frame(8'h3C, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, "noise_8e2");
    send_frame(8'h12, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, "noise_5n1");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h96, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, "b2b_0");
    send_frame(8'h69, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, "b2b_1");
    send_frame(8'h01, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, "b2b_2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                 1'b0, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid_frame();
    data_in = 8'hFF; parity_en = 1'b1; two_stop_bits = 1'b1; word_length = 2'b11; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (BD * 3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_data: tx=%b busy=%b, required tx=1 busy=0", tx, tx_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (BD * 2) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_abort: tx=%b busy=%b, required tx=1 busy=0", tx, tx_busy);
    end
    send_frame(8'hA5, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_input_changes();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
